cla_pipe_addsub: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor: the successor to the team's fixed 8-bit CLA.
- WIDTH-bit operands are split into BLOCK-bit lookahead groups; each group is one pipeline stage, and the inter-group carry is registered between stages.
- Adds add/sub mode, status flags, whole-word group PG/GG, and valid/ready handshakes on both sides, so it can sit in the ALU datapath under backpressure.

---
 rtl/cla_pipe_addsub.sv | 204 ++++++++++++++++++++
 tb/tb_cla_pipe_addsub.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: pipelined carry-lookahead adder/subtractor.
//
// WIDTH-bit operands are processed BLOCK bits per pipeline stage
// (STAGES = WIDTH/BLOCK). Each stage resolves its group with full
// lookahead and hands the group carry, running PG/GG, the finished lower
// sum bits and the still-pending upper operand bits to the next stage.
// One global advance signal moves every stage together, so a stall at the
// output freezes the whole pipe.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   input handshake (in_ready = advance, 0 in reset)
//   a, b                  operands (two's complement for the flags)
//   cin                   carry-in, ignored when sub=1
//   sub                   0: a+b+cin   1: a-b computed as a+~b+1
//   out_valid / out_ready output handshake
//   s                     sum/difference modulo 2^WIDTH
//   cout                  carry out of MSB (for sub, 1 = no borrow)
//   ovf                   signed overflow
//   zero, neg             s == 0, s[WIDTH-1]
//   pg, gg                whole-word group propagate/generate of a, b'
//
// The add/sub mode is folded into B' and the stage-0 carry-in on entry,
// so no later stage needs to carry the mode bit.
module cla_pipe_addsub #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic             pg,
  output logic             gg
);

  localparam int STAGES = WIDTH / BLOCK;

  logic             w_adv;
  logic [WIDTH-1:0] w_bx;
  logic             w_c0;

  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv & ~rst;
  assign w_bx     = sub ? ~b : b;
  assign w_c0     = sub | cin;

  // Per-bit carries as sum-of-products of the group carry-in: bit i+1 is
  // the OR over every generating position j<=i whose higher bits up to i
  // all propagate, plus the carry-in when bits 0..i all propagate.
  function automatic logic [BLOCK:0] f_carry(input logic [BLOCK-1:0] g,
                                             input logic [BLOCK-1:0] p,
                                             input logic             c0);
    logic [BLOCK:0] c;
    logic           t;
    c    = '0;
    c[0] = c0;
    for (int unsigned i = 0; i < BLOCK; i++) begin
      t = c0;
      for (int unsigned m = 0; m <= i; m++) t = t & p[m];
      c[i+1] = t;
      for (int unsigned j = 0; j <= i; j++) begin
        t = g[j];
        for (int unsigned m = j + 1; m <= i; m++) t = t & p[m];
        c[i+1] = c[i+1] | t;
      end
    end
    return c;
  endfunction

  // Group generate: carry out of the group with no carry-in.
  function automatic logic f_ggen(input logic [BLOCK-1:0] g,
                                  input logic [BLOCK-1:0] p);
    logic acc;
    logic t;
    acc = 1'b0;
    for (int unsigned j = 0; j < BLOCK; j++) begin
      t = g[j];
      for (int unsigned m = j + 1; m < BLOCK; m++) t = t & p[m];
      acc = acc | t;
    end
    return acc;
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO = k * BLOCK;
    localparam int HI = LO + BLOCK;

    // Operand bits from this group upward; the low BLOCK bits are this group.
    logic [WIDTH-LO-1:0] w_oa;
    logic [WIDTH-LO-1:0] w_ob;
    logic                w_ci;
    logic                w_pgi;
    logic                w_ggi;
    logic                w_vi;
    logic [BLOCK-1:0]    w_g;
    logic [BLOCK-1:0]    w_p;
    logic [BLOCK-1:0]    w_sum;
    logic [BLOCK:0]      w_c;
    logic [HI-1:0]       w_sn;
    logic                w_gp;
    logic                w_gg;

    logic                r_vld;
    logic                r_c;
    logic                r_pg;
    logic                r_gg;
    logic [HI-1:0]       r_s;

    if (k == 0) begin : g_head
      assign w_oa  = a;
      assign w_ob  = w_bx;
      assign w_ci  = w_c0;
      assign w_pgi = 1'b1;
      assign w_ggi = 1'b0;
      assign w_vi  = in_valid;
      assign w_sn  = w_sum;
    end else begin : g_body
      assign w_oa  = g_stg[k-1].g_up.r_a;
      assign w_ob  = g_stg[k-1].g_up.r_b;
      assign w_ci  = g_stg[k-1].r_c;
      assign w_pgi = g_stg[k-1].r_pg;
      assign w_ggi = g_stg[k-1].r_gg;
      assign w_vi  = g_stg[k-1].r_vld;
      assign w_sn  = {w_sum, g_stg[k-1].r_s};
    end

    assign w_g   = w_oa[BLOCK-1:0] & w_ob[BLOCK-1:0];
    assign w_p   = w_oa[BLOCK-1:0] ^ w_ob[BLOCK-1:0];
    assign w_c   = f_carry(w_g, w_p, w_ci);
    assign w_sum = w_p ^ w_c[BLOCK-1:0];
    assign w_gp  = &w_p;
    assign w_gg  = f_ggen(w_g, w_p);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld <= 1'b0;
        r_c   <= 1'b0;
        r_pg  <= 1'b0;
        r_gg  <= 1'b0;
        r_s   <= '0;
      end else if (w_adv) begin
        r_vld <= w_vi;
        r_c   <= w_c[BLOCK];
        r_pg  <= w_pgi & w_gp;
        // This group generates, or it propagates what the lower word generated.
        r_gg  <= w_gg | (w_gp & w_ggi);
        r_s   <= w_sn;
      end
    end

    if (k < STAGES - 1) begin : g_up
      logic [WIDTH-HI-1:0] r_a;
      logic [WIDTH-HI-1:0] r_b;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_oa[WIDTH-LO-1:BLOCK];
          r_b <= w_ob[WIDTH-LO-1:BLOCK];
        end
      end
    end

    if (k == STAGES - 1) begin : g_tail
      logic r_ovf;
      logic r_zero;
      logic r_neg;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_ovf  <= 1'b0;
          r_zero <= 1'b0;
          r_neg  <= 1'b0;
        end else if (w_adv) begin
          r_ovf  <= w_c[BLOCK] ^ w_c[BLOCK-1];
          r_zero <= ~|w_sn;
          r_neg  <= w_sn[HI-1];
        end
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].r_vld;
  assign s         = g_stg[STAGES-1].r_s;
  assign cout      = g_stg[STAGES-1].r_c;
  assign pg        = g_stg[STAGES-1].r_pg;
  assign gg        = g_stg[STAGES-1].r_gg;
  assign ovf       = g_stg[STAGES-1].g_tail.r_ovf;
  assign zero      = g_stg[STAGES-1].g_tail.r_zero;
  assign neg       = g_stg[STAGES-1].g_tail.r_neg;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Testbench for cla_pipe_addsub (WIDTH=32, BLOCK=8).
module tb_cla_pipe_addsub;

  localparam int W   = 32;
  localparam int BK  = 8;
  localparam int STG = W / BK;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] s;
  logic         cout, ovf, zero, neg, pg, gg;

  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;

  cla_pipe_addsub #(.WIDTH(W), .BLOCK(BK)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg), .pg(pg), .gg(gg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] s;
    logic cout, ovf, zero, neg, pg, gg;
  } res_t;

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin, sub;
    res_t         exp;
  } vec_t;

  res_t exp_q[$];

  // Reference: whole-word arithmetic on (W+1)-bit values.
  function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mcin, input logic msub);
    res_t       r;
    logic [W-1:0] bx;
    logic [W:0]   full;
    logic [W:0]   gen;
    logic         c0;
    bx     = msub ? ~mb : mb;
    c0     = msub ? 1'b1 : mcin;
    full   = {1'b0, ma} + {1'b0, bx} + {{W{1'b0}}, c0};
    gen    = {1'b0, ma} + {1'b0, bx};
    r.s    = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (ma[W-1] == bx[W-1]) && (r.s[W-1] != ma[W-1]);
    r.zero = (r.s == '0);
    r.neg  = r.s[W-1];
    r.pg   = ((ma ^ bx) == '1);
    r.gg   = gen[W];
    return r;
  endfunction

  function automatic res_t dut_res();
    return {s, cout, ovf, zero, neg, pg, gg};
  endfunction

  function automatic vec_t mk(input logic [W-1:0] va, input logic [W-1:0] vb,
                              input logic vcin, input logic vsub,
                              input logic [W-1:0] es, input logic [5:0] ef);
    vec_t v;
    v.a   = va;
    v.b   = vb;
    v.cin = vcin;
    v.sub = vsub;
    v.exp = {es, ef};
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 9))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard: record accepted beats, compare every valid output against
  // the oldest outstanding beat (also while stalled), pop on transfer.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      check("in_ready_in_reset", 64'(in_ready), 64'd0);
    end else begin
      check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL spurious_beat: got s=%h with nothing outstanding", s);
        end else begin
          check("beat", 64'(dut_res()), 64'(exp_q[0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
    end
  end

  vec_t tbl[9];
  int   lat;
  int   n0;
  int   idx;
  logic took;
  logic [W-1:0] bpa[8];
  logic [W-1:0] bpb[8];

  initial begin
    //                a             b             cin   sub   s             {cout,ovf,zero,neg,pg,gg}
    tbl[0] = mk(32'd5,        32'hFFFF_FFFD, 1'b0, 1'b0, 32'd2,        6'b100001);
    tbl[1] = mk(32'h7FFF_FFFF, 32'd1,        1'b0, 1'b0, 32'h8000_0000, 6'b010100);
    tbl[2] = mk(32'hFFFF_FFFF, 32'd0,        1'b1, 1'b0, 32'd0,        6'b101010);
    tbl[3] = mk(32'd5,        32'd5,         1'b0, 1'b1, 32'd0,        6'b101010);
    tbl[4] = mk(32'd3,        32'd5,         1'b0, 1'b1, 32'hFFFF_FFFE, 6'b000100);
    tbl[5] = mk(32'd0,        32'd0,         1'b1, 1'b1, 32'd0,        6'b101010);
    tbl[6] = mk(32'h8000_0000, 32'd1,        1'b0, 1'b1, 32'h7FFF_FFFF, 6'b110001);
    tbl[7] = mk(32'h0000_00FF, 32'd1,        1'b0, 1'b0, 32'h0000_0100, 6'b000000);
    tbl[8] = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 6'b100101);

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("in_ready_held_low_in_reset", 64'(in_ready), 64'd0);
    rst = 1'b0;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_outputs", 64'(dut_res()), 64'd0);

    // Directed vectors, one beat at a time
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      a = tbl[i].a; b = tbl[i].b; cin = tbl[i].cin; sub = tbl[i].sub;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
        tick();
        lat++;
      end
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(STG));
      check($sformatf("vec%0d_result", i), 64'(dut_res()), 64'(tbl[i].exp));
      tick();
    end

    // Backpressure: 8 distinct beats, out_ready low for cycles 5..7
    for (int i = 0; i < 8; i++) begin
      bpa[i] = $urandom ^ (32'h1111_1111 * i);
      bpb[i] = $urandom;
    end
    n0  = n_out;
    idx = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready = !(cyc >= 5 && cyc <= 7);
      if (idx < 8) begin
        in_valid = 1'b1;
        a = bpa[idx]; b = bpb[idx]; sub = idx[0]; cin = idx[1];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc >= 5 && cyc <= 7)
        check($sformatf("bp_in_ready_stall_c%0d", cyc), 64'(in_ready), 64'd0);
      took = in_valid && in_ready;
      tick();
      if (took) idx++;
    end
    out_ready = 1'b1;
    check("bp_all_accepted", 64'(idx), 64'd8);
    check("bp_all_delivered", 64'(n_out - n0), 64'd8);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = $urandom; b = $urandom; cin = 1'b0; sub = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    tick();
    rst = 1'b0;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    n0 = n_out;
    repeat (6) tick();
    check("midrst_no_old_beats", 64'(n_out - n0), 64'd0);
    a = 32'h1234_5678; b = 32'h0FED_CBA9; cin = 1'b1; sub = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("midrst_new_latency", 64'(lat), 64'(STG));
    check("midrst_new_result", 64'(dut_res()), 64'(model(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0)));
    tick();

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      a   = pick();
      b   = pick();
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      tick();
    end

    // Drain
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
